// File: rtl/me_dmem_ctrl_pkg.sv
// Shared types and constants for the MEM-stage data-memory controller.
package me_dmem_ctrl_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  localparam int unsigned TIMEOUT_DEF = 255;
  localparam logic [31:0] ALIGN_MASK  = 32'h0000_0003;

endpackage

// File: rtl/me_dmem_ctrl.sv
// MEM-stage data-memory controller: req/ack handshake with a variable-latency
// memory, pipeline stall while an access is outstanding, registered MEM/WB outputs.
module me_dmem_ctrl
  import me_dmem_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ME_DMWr,
  input  logic        ME_DMRd,
  input  logic        ME_RFWr,
  input  logic        ME_WD_Src,
  input  logic [4:0]  ME_Rd,
  input  logic [31:0] ME_ALURes,
  input  logic [31:0] ME_RTVal,
  output logic        ME_Stall,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata,
  input  logic        dm_ack,
  output logic        WB_RFWr,
  output logic        WB_WD_Src,
  output logic [4:0]  WB_Rd,
  output logic [31:0] WB_ALURes,
  output logic [31:0] WB_MemData,
  output logic        WB_Exc
);

  localparam int unsigned CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          req_q, req_d, we_q, we_d;
  logic [31:0]   addr_q, addr_d, wdata_q, wdata_d;
  logic          wb_rfwr_q, wb_rfwr_d, wb_src_q, wb_src_d, wb_exc_q, wb_exc_d;
  logic [4:0]    wb_rd_q, wb_rd_d;
  logic [31:0]   wb_alu_q, wb_alu_d, wb_mem_q, wb_mem_d;

  logic acc, misal;
  assign acc   = ME_DMWr | ME_DMRd;
  assign misal = |(ME_ALURes & ALIGN_MASK);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wb_rfwr_d = wb_rfwr_q;
    wb_src_d  = wb_src_q;
    wb_rd_d   = wb_rd_q;
    wb_alu_d  = wb_alu_q;
    wb_mem_d  = wb_mem_q;
    wb_exc_d  = wb_exc_q;
    ME_Stall  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!acc) begin
          wb_rfwr_d = ME_RFWr;
          wb_src_d  = ME_WD_Src;
          wb_rd_d   = ME_Rd;
          wb_alu_d  = ME_ALURes;
          wb_mem_d  = 32'h0;
          wb_exc_d  = 1'b0;
        end else if (misal) begin
          // Misaligned access never reaches memory; it retires as an exception.
          wb_rfwr_d = 1'b0;
          wb_src_d  = ME_WD_Src;
          wb_rd_d   = ME_Rd;
          wb_alu_d  = ME_ALURes;
          wb_mem_d  = 32'h0;
          wb_exc_d  = 1'b1;
        end else begin
          ME_Stall  = 1'b1;
          state_d   = ST_BUSY;
          cnt_d     = '0;
          req_d     = 1'b1;
          we_d      = ME_DMWr;
          addr_d    = ME_ALURes;
          wdata_d   = ME_RTVal;
          wb_rfwr_d = 1'b0;
          wb_exc_d  = 1'b0;
        end
      end
      ST_BUSY: begin
        if (dm_ack) begin
          state_d   = ST_IDLE;
          cnt_d     = '0;
          req_d     = 1'b0;
          wb_rfwr_d = ME_RFWr;
          wb_src_d  = ME_WD_Src;
          wb_rd_d   = ME_Rd;
          wb_alu_d  = ME_ALURes;
          wb_mem_d  = we_q ? 32'h0 : dm_rdata;
          wb_exc_d  = 1'b0;
        end else if (cnt_q != CNT_LAST) begin
          ME_Stall  = 1'b1;
          cnt_d     = cnt_q + CW'(1);
          wb_rfwr_d = 1'b0;
        end else begin
          // Give up: release the pipeline and flag the instruction.
          state_d   = ST_IDLE;
          cnt_d     = '0;
          req_d     = 1'b0;
          wb_rfwr_d = 1'b0;
          wb_exc_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= 32'h0;
      wdata_q   <= 32'h0;
      wb_rfwr_q <= 1'b0;
      wb_src_q  <= 1'b0;
      wb_rd_q   <= 5'h0;
      wb_alu_q  <= 32'h0;
      wb_mem_q  <= 32'h0;
      wb_exc_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wb_rfwr_q <= wb_rfwr_d;
      wb_src_q  <= wb_src_d;
      wb_rd_q   <= wb_rd_d;
      wb_alu_q  <= wb_alu_d;
      wb_mem_q  <= wb_mem_d;
      wb_exc_q  <= wb_exc_d;
    end
  end

  assign dm_req     = req_q;
  assign dm_we      = we_q;
  assign dm_addr    = addr_q;
  assign dm_wdata   = wdata_q;
  assign WB_RFWr    = wb_rfwr_q;
  assign WB_WD_Src  = wb_src_q;
  assign WB_Rd      = wb_rd_q;
  assign WB_ALURes  = wb_alu_q;
  assign WB_MemData = wb_mem_q;
  assign WB_Exc     = wb_exc_q;

endmodule

// File: doc/me_dmem_ctrl.md
# me_dmem_ctrl

MEM-stage data-memory controller: consumes the ME_* bundle driven by the EX/MEM pipeline register, runs a req/ack handshake with a variable-latency data memory, stalls the pipeline while an access is outstanding, and registers the MEM/WB outputs. It is the responder for the memory-control signals the EX/MEM register produces and sits between that register and write-back.

## Interface

- TIMEOUT, 255: max cycles in BUSY waiting for dm_ack before abort (1..65535)
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- ME_DMWr  in  1  store request
- ME_DMRd  in  1  load request
- ME_RFWr  in  1  register-file write enable of instruction in ME
- ME_WD_Src  in  1  write-back data select (1 = memory data)
- ME_Rd  in  5  destination register
- ME_ALURes  in  32  effective address / ALU result
- ME_RTVal  in  32  store data
- ME_Stall  out  1  hold IF..EX/MEM this cycle (combinational)
- dm_req  out  1  memory request, registered
- dm_we  out  1  1 = write, registered
- dm_addr  out  32  word-aligned address, registered
- dm_wdata  out  32  store data, registered
- dm_rdata  in  32  load data, valid with dm_ack
- dm_ack  in  1  one-cycle completion strobe
- WB_RFWr, WB_WD_Src  out  1 each  registered controls to WB
- WB_Rd  out  5  registered
- WB_ALURes, WB_MemData  out  32 each  registered
- WB_Exc  out  1  registered; 1 = aborted access (misaligned or timeout)

## Operation

- FSM states: IDLE, BUSY. Reset: IDLE, every output 0, timeout counter 0.
- acc = ME_DMWr | ME_DMRd; wr = ME_DMWr (write wins if both set; read ignored).
- IDLE, acc=0: WB_* <= ME_* (WB_MemData <= 0, WB_Exc <= 0); ME_Stall=0.
- IDLE, acc=1, ME_ALURes[1:0]!=0: no request; WB_Exc <= 1, WB_RFWr <= 0, WB_Rd/WB_ALURes passed; ME_Stall=0.
- IDLE, acc=1, aligned: ME_Stall=1; next state BUSY; dm_req <= 1, dm_we <= wr, dm_addr <= ME_ALURes, dm_wdata <= ME_RTVal; WB_RFWr <= 0 (bubble).
- BUSY, dm_ack=1: ME_Stall=0; dm_req <= 0; WB_* <= ME_*, WB_MemData <= (dm_we ? 0 : dm_rdata), WB_Exc <= 0; state <= IDLE; counter <= 0.
- BUSY, dm_ack=0, counter < TIMEOUT-1: ME_Stall=1; counter++; WB_RFWr <= 0.
- BUSY, dm_ack=0, counter = TIMEOUT-1: abort; ME_Stall=0; dm_req <= 0; WB_Exc <= 1, WB_RFWr <= 0; state <= IDLE.
- dm_ack in IDLE ignored. dm_addr/dm_we/dm_wdata stable while dm_req=1.
- ME_* inputs are held by upstream while ME_Stall=1; block does not latch them beyond dm_*.

## Timing

- Non-memory instruction: 1 cycle in ME, WB valid next edge.
- Memory access, ack in first BUSY cycle: 2 cycles in ME (stall asserted 1 cycle); WB valid at edge ending the ack cycle.
- Each ack-less BUSY cycle adds one stall cycle; worst case 1+TIMEOUT cycles.
- ME_Stall depends combinationally on state, ME_DMWr/ME_DMRd, ME_ALURes[1:0], dm_ack, counter — no dependence on dm_rdata.
- Reset mid-BUSY: dm_req drops immediately (async), FSM IDLE; a late dm_ack afterwards ignored.
- Counter width = clog2(TIMEOUT)+1; never wraps (cleared on leaving BUSY).

## Structure

- Shared package: state enum (IDLE, BUSY), TIMEOUT default, alignment-mask constant.
- Single module; timeout counter inline. No sub-module.

## Test plan

- ALU instr (ME_RFWr=1, ME_Rd=5, ME_ALURes=0x1234) in IDLE -> ME_Stall=0, next cycle WB_RFWr=1, WB_Rd=5, WB_ALURes=0x1234, dm_req stays 0.
- Load addr 0x100, dm_ack+dm_rdata=0xDEADBEEF 3 cycles after dm_req -> ME_Stall high 4 cycles, dm_addr=0x100, dm_we=0, then WB_MemData=0xDEADBEEF, WB_RFWr=1.
- Store addr 0x200, RTVal=0xCAFEF00D, ack in first BUSY cycle -> dm_we=1, dm_wdata=0xCAFEF00D, one stall cycle, WB_RFWr=ME_RFWr, WB_MemData=0.
- Load addr 0x102 -> no dm_req, no stall, WB_Exc=1, WB_RFWr=0.
- TIMEOUT=4, load with no ack -> dm_req high 4 cycles, then dropped, WB_Exc=1, FSM IDLE; later spurious dm_ack ignored.
- rst pulse while BUSY -> dm_req and all WB_* 0 immediately; after release, fresh load completes normally.
